// File: rtl/pwm_mc_timer.sv
// ---------------------------------------------------------------------------
// pwm_mc_timer
//   Multi-channel PWM timer core. A single prescaled time-base drives NUM_CH
//   compare channels. The time-base counts up, down or center-aligned
//   (up/down). The period and the compare values are double-buffered: writes
//   land in shadow registers and are copied to the active registers on the
//   update event (counter wrap). While the time-base is disabled the active
//   registers follow the shadows every cycle, so a configuration written
//   before start-up takes effect at once.
//
//   Optional build macro: PWM_ONESHOT_EN adds the oneshot input and the done
//   output. With oneshot=1 the counter stops at its wrap target on the first
//   update event after en rises. done stays set until en goes low and high
//   again.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   en         time-base enable (0 holds prescaler and counter)
//   upnotdown  1 = count up, 0 = count down (ignored in center mode)
//   center_en  1 = center-aligned up/down counting
//   prescale   tick every prescale+1 clk cycles
//   wr_en      shadow register write strobe
//   wr_addr    0 = period, 1+2k = compare1[k], 2+2k = compare2[k]
//   wr_data    write data
//   ch_en      per-channel output enable
//   ch_mode    per channel [2k+1:2k]: 00 left, 01 right, 10 window, 11 off
//   count_val  current counter value
//   update     one-clk pulse after each update event
//   pwm_out    registered PWM outputs
//   oneshot    (PWM_ONESHOT_EN only) stop on the first update event
//   done       (PWM_ONESHOT_EN only) sticky one-shot completion flag
// ---------------------------------------------------------------------------
module pwm_mc_timer #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8,
    localparam int ADDR_W = $clog2(2*NUM_CH+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                upnotdown,
    input  logic                center_en,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [CNT_W-1:0]    wr_data,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic [2*NUM_CH-1:0] ch_mode,
    output logic [CNT_W-1:0]    count_val,
    output logic                update,
    output logic [NUM_CH-1:0]   pwm_out
`ifdef PWM_ONESHOT_EN
    ,
    input  logic                oneshot,
    output logic                done
`endif
);

    // Time-base state
    logic [PRESC_W-1:0] psc_reg, psc_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               dir_reg, dir_next;      // center mode: 1 = counting up
    logic               update_reg;
    logic               tick;
    logic               update_event;

    // Shadow / active configuration
    logic [CNT_W-1:0]              period_shadow_reg, period_active_reg;
    logic [NUM_CH-1:0][CNT_W-1:0]  cmp1_shadow_reg, cmp1_active_reg;
    logic [NUM_CH-1:0][CNT_W-1:0]  cmp2_shadow_reg, cmp2_active_reg;

    logic [NUM_CH-1:0] pwm_reg, pwm_next;

    // run: counter may advance on a tick; stop_on_wrap: freeze at wrap target
    logic run;
    logic stop_on_wrap;

`ifdef PWM_ONESHOT_EN
    logic en_d_reg;
    logic done_reg;
    logic en_rise;

    assign en_rise      = en & ~en_d_reg;
    // A rising en restarts a finished one-shot in the same cycle.
    assign run          = ~done_reg | en_rise;
    assign stop_on_wrap = oneshot;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_d_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            en_d_reg <= en;
            if (en_rise)
                done_reg <= 1'b0;
            if (update_event && oneshot)
                done_reg <= 1'b1;
        end
    end

    assign done = done_reg;
`else
    assign run          = 1'b1;
    assign stop_on_wrap = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Prescaler and counter next-state
    // -----------------------------------------------------------------------
    always_comb begin
        tick         = en && (psc_reg == prescale);
        psc_next     = psc_reg;
        count_next   = count_reg;
        dir_next     = dir_reg;
        update_event = 1'b0;

        if (en)
            psc_next = tick ? '0 : psc_reg + 1'b1;

        if (tick && run) begin
            if (center_en) begin
                if (count_reg == '0) begin
                    // Leaving the bottom is the update event in center mode.
                    update_event = 1'b1;
                    dir_next     = 1'b1;
                    count_next   = (period_active_reg == '0) ? '0 : CNT_W'(1);
                end else if (count_reg >= period_active_reg) begin
                    // >= so a count left above a shrunk period turns around.
                    dir_next   = 1'b0;
                    count_next = count_reg - 1'b1;
                end else if (dir_reg) begin
                    count_next = count_reg + 1'b1;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end else if (upnotdown) begin
                if (count_reg >= period_active_reg) begin
                    update_event = 1'b1;
                    count_next   = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end else begin
                if (count_reg == '0) begin
                    update_event = 1'b1;
                    count_next   = period_active_reg;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end

            // One-shot: park on the wrap target (only differs from the
            // normal next value in center mode, where it would move to 1).
            if (update_event && stop_on_wrap && center_en)
                count_next = '0;
        end
    end

    // -----------------------------------------------------------------------
    // PWM decode, one channel per generate instance
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]       mode;
            logic [CNT_W-1:0] c1;
            logic [CNT_W-1:0] c2;

            assign mode = ch_mode[2*gi +: 2];
            assign c1   = cmp1_active_reg[gi];
            assign c2   = cmp2_active_reg[gi];

            // Window with c1 >= c2 is empty, left with c1 = 0 is never true.
            assign pwm_next[gi] = ch_en[gi] && (
                  ((mode == 2'b00) && (count_reg <  c1))
               || ((mode == 2'b01) && (count_reg >= c1))
               || ((mode == 2'b10) && (count_reg >= c1) && (count_reg < c2)));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            psc_reg           <= '0;
            count_reg         <= '0;
            dir_reg           <= 1'b1;
            update_reg        <= 1'b0;
            pwm_reg           <= '0;
            period_shadow_reg <= '0;
            period_active_reg <= '0;
            cmp1_shadow_reg   <= '0;
            cmp1_active_reg   <= '0;
            cmp2_shadow_reg   <= '0;
            cmp2_active_reg   <= '0;
        end else begin
            psc_reg    <= psc_next;
            count_reg  <= count_next;
            dir_reg    <= dir_next;
            update_reg <= update_event;
            pwm_reg    <= pwm_next;

            if (wr_en && (wr_addr == '0))
                period_shadow_reg <= wr_data;

            // Non-blocking read of the shadow: a write colliding with the
            // update event waits for the next one.
            if (update_event || !en)
                period_active_reg <= period_shadow_reg;

            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en && (wr_addr == ADDR_W'(2*k+1)))
                    cmp1_shadow_reg[k] <= wr_data;
                if (wr_en && (wr_addr == ADDR_W'(2*k+2)))
                    cmp2_shadow_reg[k] <= wr_data;
                if (update_event || !en) begin
                    cmp1_active_reg[k] <= cmp1_shadow_reg[k];
                    cmp2_active_reg[k] <= cmp2_shadow_reg[k];
                end
            end
        end
    end

    assign count_val = count_reg;
    assign update    = update_reg;
    assign pwm_out   = pwm_reg;

endmodule

// File: tb/tb_pwm_mc_timer.sv
// ---------------------------------------------------------------------------
// tb_pwm_mc_timer
//   Directed bench for pwm_mc_timer (NUM_CH=4, CNT_W=16, PRESC_W=8).
//   Compare-mode bounds come from a vector table; counting modes, double
//   buffering and enable gating are hand-written sequences with hand-derived
//   expected values. Define PWM_ONESHOT_EN to also exercise the one-shot.
// ---------------------------------------------------------------------------
module tb_pwm_mc_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        upnotdown;
    logic        center_en;
    logic [7:0]  prescale;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  ch_en;
    logic [7:0]  ch_mode;
    logic [15:0] count_val;
    logic        update;
    logic [3:0]  pwm_out;
`ifdef PWM_ONESHOT_EN
    logic        oneshot;
    logic        done;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pwm_mc_timer #(.NUM_CH(4), .CNT_W(16), .PRESC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .upnotdown (upnotdown),
        .center_en (center_en),
        .prescale  (prescale),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ch_en     (ch_en),
        .ch_mode   (ch_mode),
        .count_val (count_val),
        .update    (update),
        .pwm_out   (pwm_out)
`ifdef PWM_ONESHOT_EN
        ,
        .oneshot   (oneshot),
        .done      (done)
`endif
    );

    typedef struct {
        logic [1:0]  mode;
        logic        chen;
        logic [15:0] c1;
        logic [15:0] c2;
        logic [5:0]  mask;   // expected pwm_out[0] for count 0..5
    } vec_t;

    vec_t vecs[8];

    // Up, P=9 then P=3 then P=6: count after each edge.
    int exp4[29] = '{1,2,3,4,5,6,7,8,9,0, 1,2,3,0, 1,2,3,0, 1,2,3,0,
                     1,2,3,4,5,6,0};
    // Down, P=2, en low for three edges.
    int exp6[10] = '{2,1,0,2,2,2,2,1,0,2};
    // Center, P=3, one full cycle of counter values.
    int ctr[6]   = '{0,1,2,3,2,1};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req)
            passes++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 16'd7;
        step();
        step();
        check("rst_count",  count_val, 0);
        check("rst_pwm",    pwm_out,   0);
        check("rst_update", update,    0);
        rst       = 1'b0;
        en        = 1'b0;
        wr_en     = 1'b0;
        upnotdown = 1'b1;
        center_en = 1'b0;
        prescale  = 8'd0;
        ch_en     = 4'b0;
        ch_mode   = 8'b0;
`ifdef PWM_ONESHOT_EN
        oneshot   = 1'b0;
`endif
        $display("reset done: count=%0d pwm=%b update=%b", count_val, pwm_out, update);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; upnotdown = 1'b1; center_en = 1'b0;
        prescale = 8'd0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'd0;
        ch_en = 4'b0; ch_mode = 8'b0;
`ifdef PWM_ONESHOT_EN
        oneshot = 1'b0;
`endif

        vecs[0] = '{2'b00, 1'b1, 16'd2, 16'd0, 6'b000011}; // left C1=2
        vecs[1] = '{2'b00, 1'b1, 16'd0, 16'd0, 6'b000000}; // left C1=0
        vecs[2] = '{2'b00, 1'b1, 16'd6, 16'd0, 6'b111111}; // left C1>P
        vecs[3] = '{2'b01, 1'b1, 16'd3, 16'd0, 6'b111000}; // right C1=3
        vecs[4] = '{2'b10, 1'b1, 16'd1, 16'd4, 6'b001110}; // window 1..3
        vecs[5] = '{2'b10, 1'b1, 16'd4, 16'd2, 6'b000000}; // window C1>=C2
        vecs[6] = '{2'b11, 1'b1, 16'd6, 16'd0, 6'b000000}; // reserved
        vecs[7] = '{2'b00, 1'b0, 16'd6, 16'd0, 6'b000000}; // ch_en=0

        // 1: reset with writes pending; period stays 0 -> every tick updates
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            $display("t1 k=%0d count=%0d update=%b", k, count_val, update);
            check("t1_count",  count_val, 0);
            check("t1_update", update,    1);
        end

        // 2: up, prescale=1, P=4, ch0 left C1=2
        do_reset();
        prescale = 8'd1;
        wr(4'd0, 16'd4);
        wr(4'd1, 16'd2);
        ch_en = 4'b0001;
        step();
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            $display("t2 k=%0d count=%0d pwm=%b update=%b", k, count_val, pwm_out, update);
            check("t2_count",  count_val, ((k+1)/2) % 5);
            check("t2_pwm0",   pwm_out[0], (((k/2) % 5) < 2) ? 1 : 0);
            check("t2_update", update, (k % 10 == 9) ? 1 : 0);
        end

        // 3: center, prescale=0, P=3, ch1 window 1..3
        do_reset();
        wr(4'd0, 16'd3);
        wr(4'd3, 16'd1);
        wr(4'd4, 16'd3);
        ch_en     = 4'b0010;
        ch_mode   = 8'b0000_1000;
        center_en = 1'b1;
        step();
        en = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
            $display("t3 k=%0d count=%0d pwm=%b update=%b", k, count_val, pwm_out, update);
            check("t3_count",  count_val, ctr[(k+1) % 6]);
            check("t3_pwm1",   pwm_out[1], (ctr[k % 6] == 1 || ctr[k % 6] == 2) ? 1 : 0);
            check("t3_update", update, (k % 6 == 0) ? 1 : 0);
        end

        // 4: double buffering, mid-period write and update collision
        do_reset();
        wr(4'd0, 16'd9);
        step();
        en = 1'b1;
        for (int k = 0; k < 29; k++) begin
            step();
            $display("t4 k=%0d count=%0d update=%b", k, count_val, update);
            check("t4_count", count_val, exp4[k]);
            check("t4_update", update,
                  (k == 9 || k == 13 || k == 17 || k == 21 || k == 28) ? 1 : 0);
            if (k == 3 || k == 16) begin
                wr_en   = 1'b1;
                wr_addr = 4'd0;
                wr_data = (k == 3) ? 16'd3 : 16'd6;
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;

        // 5: compare-mode bounds, P=5, table-driven
        for (int i = 0; i < 8; i++) begin
            do_reset();
            wr(4'd0, 16'd5);
            wr(4'd1, vecs[i].c1);
            wr(4'd2, vecs[i].c2);
            ch_en   = {3'b000, vecs[i].chen};
            ch_mode = {6'b000000, vecs[i].mode};
            step();
            en = 1'b1;
            for (int k = 0; k < 6; k++) begin
                step();
                $display("t5 v=%0d k=%0d count=%0d pwm0=%b", i, k, count_val, pwm_out[0]);
                check("t5_pwm0",  pwm_out[0], vecs[i].mask[k]);
                check("t5_count", count_val, (k+1) % 6);
            end
        end

        // 6: down, P=2, en low for three edges mid-count
        do_reset();
        wr(4'd0, 16'd2);
        step();
        upnotdown = 1'b0;
        en        = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            $display("t6 k=%0d count=%0d update=%b", k, count_val, update);
            check("t6_count",  count_val, exp6[k]);
            check("t6_update", update, (k == 0 || k == 3 || k == 9) ? 1 : 0);
            if (k == 3) en = 1'b0;
            if (k == 6) en = 1'b1;
        end

`ifdef PWM_ONESHOT_EN
        // 6b: one-shot, down P=2: stops at 2 and restarts after en 0 -> 1
        do_reset();
        wr(4'd0, 16'd2);
        step();
        upnotdown = 1'b0;
        oneshot   = 1'b1;
        en        = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            $display("t6b k=%0d count=%0d done=%b update=%b", k, count_val, done, update);
            check("os_count",  count_val, 2);
            check("os_done",   done, 1);
            check("os_update", update, (k == 0) ? 1 : 0);
        end
        en = 1'b0;
        step();
        check("os_done_hold", done, 1);
        en = 1'b1;
        step();
        check("os_restart_count", count_val, 1);
        check("os_restart_done",  done, 0);
        step();
        check("os_run_count", count_val, 0);
        step();
        check("os_stop_count", count_val, 2);
        check("os_stop_done",  done, 1);
        step();
        check("os_stay_count", count_val, 2);
`endif

        // mid-operation reset returns everything to idle
        do_reset();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
